lc3_wb_arbiter: RTL

Write-back arbiter for the LC-3 register file's single write port. Three requesters share the port through per-requester valid/ready handshakes: ALU write-back, memory-load write-back, and the debug console. Each cycle at most one requester is granted, chosen by round-robin. The granted write is presented to the register file as a registered one-cycle strobe, and the NZP condition-code register is updated from the written value when the requester asks for it.

---
 rtl/lc3_wb_arbiter.sv | 110 +++++++++++
 1 files changed

// File: rtl/lc3_wb_arbiter.sv
// Round-robin write-back arbiter for the LC-3 register file's single write port.
// Grants one of ALU / load / debug per cycle, registers the write strobe and maintains NZP.
module lc3_wb_arbiter #(
   parameter int unsigned NREQ = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [3*NREQ-1:0]     req_dr,
   input  logic [16*NREQ-1:0]    req_data,
   input  logic [NREQ-1:0]       req_setcc,
   output logic [NREQ-1:0]       req_ready,
   input  logic                  freeze,
   output logic                  rf_we,
   output logic [2:0]            rf_dr,
   output logic [15:0]           rf_d,
   output logic [2:0]            nzp,
   output logic [15:0]           wb_count
);

   localparam int unsigned DR_W  = 3;
   localparam int unsigned D_W   = 16;
   localparam int unsigned CNT_W = 16;
   localparam int unsigned PTR_W = 2;

   logic [PTR_W-1:0] ptr;
   logic [PTR_W-1:0] start;
   logic [PTR_W-1:0] idx;
   logic [PTR_W-1:0] gidx;
   logic [PTR_W-1:0] next_ptr;
   logic [2:0]       sum;
   logic             found;
   logic [NREQ-1:0]  grant;
   logic [DR_W-1:0]  sel_dr;
   logic [D_W-1:0]   sel_d;
   logic             sel_setcc;

   function automatic logic [2:0] cc_of(input logic [D_W-1:0] v);
      if (v[D_W-1])        return 3'b100;
      else if (v == '0)    return 3'b010;
      else                 return 3'b001;
   endfunction

   // First valid requester in rotation order ptr, ptr+1, ptr+2; unreachable ptr=3 acts as 0
   always_comb begin
      grant = '0;
      gidx  = '0;
      idx   = '0;
      sum   = '0;
      found = 1'b0;
      start = (ptr == 2'd3) ? 2'd0 : ptr;
      for (int unsigned o = 0; o < 3; o++) begin
         sum = 3'(start) + 3'(o);
         idx = (sum >= 3'd3) ? 2'(sum - 3'd3) : 2'(sum);
         if (!found && req_valid[idx]) begin
            found = 1'b1;
            gidx  = idx;
         end
      end
      if (found && !freeze && !rst) grant[gidx] = 1'b1;
   end

   assign req_ready = grant;

   always_comb begin
      sel_dr    = req_dr[2:0];
      sel_d     = req_data[15:0];
      sel_setcc = req_setcc[0];
      case (gidx)
         2'd0: begin
            sel_dr    = req_dr[2:0];
            sel_d     = req_data[15:0];
            sel_setcc = req_setcc[0];
         end
         2'd1: begin
            sel_dr    = req_dr[5:3];
            sel_d     = req_data[31:16];
            sel_setcc = req_setcc[1];
         end
         default: begin
            sel_dr    = req_dr[8:6];
            sel_d     = req_data[47:32];
            sel_setcc = req_setcc[2];
         end
      endcase
      next_ptr = (gidx == 2'd2) ? 2'd0 : gidx + 2'd1;
   end

   // Write strobe, pointer, condition codes and accepted-write counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rf_we    <= 1'b0;
         rf_dr    <= '0;
         rf_d     <= '0;
         nzp      <= 3'b010;
         wb_count <= '0;
         ptr      <= '0;
      end else if (|grant) begin
         rf_we    <= 1'b1;
         rf_dr    <= sel_dr;
         rf_d     <= sel_d;
         ptr      <= next_ptr;
         wb_count <= wb_count + CNT_W'(1);
         if (sel_setcc) nzp <= cc_of(sel_d);
      end else begin
         rf_we <= 1'b0;
      end
   end

endmodule
